// File: rtl/cache_pkg.sv
// Shared widths, defaults and helpers for the cache tag lookup path.
// Optional feature macro used elsewhere: TAG_MATCH_MULTI_HIT_EN.
package cache_pkg;

  localparam int TAG_W = 8;
  localparam int WAYS  = 4;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int WAY_IDX_W = clog2(WAYS);

  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [WAY_IDX_W-1:0] way_idx_t;
  typedef logic [WAYS-1:0]      match_vec_t;

endpackage

// File: rtl/way_tag_compare.sv
// One way of the tag comparator: stored tag equals lookup tag,
// gated by the way's valid bit. Purely combinational.
module way_tag_compare #(
  parameter int TAG_W = 8
) (
  input  logic             valid_i,
  input  logic [TAG_W-1:0] stored_tag_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             match_o
);

  assign match_o = valid_i &&
                   (stored_tag_i == lookup_tag_i);

endmodule

// File: rtl/tag_match_unit.sv
// Two-stage N-way tag comparator with valid/ready on both sides.
// Define TAG_MATCH_MULTI_HIT_EN to add the out_multi_hit flag.
module tag_match_unit #(
  parameter  int TAG_W     = cache_pkg::TAG_W,
  parameter  int WAYS      = cache_pkg::WAYS,
  localparam int WAY_IDX_W = cache_pkg::clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [WAYS*TAG_W-1:0] in_way_tags,
  input  logic [WAYS-1:0]       in_way_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_hit,
  output logic [WAYS-1:0]       out_hit_onehot,
  output logic [WAY_IDX_W-1:0]  out_hit_way
`ifdef TAG_MATCH_MULTI_HIT_EN
  ,
  output logic                  out_multi_hit
`endif
);

  logic                 s1_valid_q;
  logic [WAYS-1:0]      match_d;
  logic [WAYS-1:0]      match_q;
  logic                 s1_adv;
  logic                 s2_adv;
  logic                 out_valid_q;
  logic                 hit_q;
  logic [WAYS-1:0]      onehot_q;
  logic [WAY_IDX_W-1:0] way_q;
  logic [WAYS-1:0]      sel_oh_d;
  logic [WAY_IDX_W-1:0] sel_idx_d;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    way_tag_compare #(
      .TAG_W(TAG_W)
    ) u_cmp (
      .valid_i     (in_way_valid[g]),
      .stored_tag_i(in_way_tags[g*TAG_W +: TAG_W]),
      .lookup_tag_i(in_tag),
      .match_o     (match_d[g])
    );
  end

  // A stage advances when its successor is empty or draining.
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && !rst;

  // Priority encoder: scan downwards so the lowest index wins.
  always_comb begin
    sel_oh_d  = '0;
    sel_idx_d = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match_q[i]) begin
        sel_oh_d    = '0;
        sel_oh_d[i] = 1'b1;
        sel_idx_d   = WAY_IDX_W'(i);
      end
    end
  end

  // Stage 1 occupancy; reset drops any in-flight lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
    end
  end

  // Stage 1 match vector, loaded only on an accepted lookup.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      match_q <= match_d;
    end
  end

  // Stage 2 result registers; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      onehot_q    <= '0;
      way_q       <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        hit_q    <= |match_q;
        onehot_q <= sel_oh_d;
        way_q    <= sel_idx_d;
      end
    end
  end

`ifdef TAG_MATCH_MULTI_HIT_EN
  logic multi_d;
  logic multi_q;

  // Clearing the lowest set bit leaves something iff 2+ matched.
  assign multi_d = |(match_q & (match_q - WAYS'(1)));

  // Multi-hit flag travels alongside the stage 2 result.
  always_ff @(posedge clk) begin
    if (rst) begin
      multi_q <= 1'b0;
    end else if (s2_adv && s1_valid_q) begin
      multi_q <= multi_d;
    end
  end

  assign out_multi_hit = multi_q;
`endif

  assign out_valid      = out_valid_q;
  assign out_hit        = hit_q;
  assign out_hit_onehot = onehot_q;
  assign out_hit_way    = way_q;

endmodule

// File: tb/tb_tag_match_unit.sv
// Directed plus randomized bench for tag_match_unit.
// Honours TAG_MATCH_MULTI_HIT_EN when defined.
module tb_tag_match_unit;

  localparam int TAG_W = 8;
  localparam int WAYS  = 4;
  localparam int IW    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [TAG_W-1:0]      in_tag;
  logic [WAYS*TAG_W-1:0] in_way_tags;
  logic [WAYS-1:0]       in_way_valid;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_hit;
  logic [WAYS-1:0]       out_hit_onehot;
  logic [IW-1:0]         out_hit_way;
  logic                  obs_multi;
`ifdef TAG_MATCH_MULTI_HIT_EN
  logic                  out_multi_hit;
  assign obs_multi = out_multi_hit;
`else
  assign obs_multi = 1'b0;
`endif

  tag_match_unit #(
    .TAG_W(TAG_W),
    .WAYS (WAYS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_tag        (in_tag),
    .in_way_tags   (in_way_tags),
    .in_way_valid  (in_way_valid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_hit       (out_hit),
    .out_hit_onehot(out_hit_onehot),
    .out_hit_way   (out_hit_way)
`ifdef TAG_MATCH_MULTI_HIT_EN
    ,
    .out_multi_hit (out_multi_hit)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            hit;
    logic [WAYS-1:0] oh;
    logic [IW-1:0]   way;
    logic            multi;
  } res_t;

  res_t expq[$];
  res_t held_val;
  bit   held;
  bit   expect_idle;
  int   checks;
  int   errors;
  int   delivered;
  int   accepted;

  // Expected result from the lookup rules: first valid equal way.
  function automatic res_t model(
    input logic [TAG_W-1:0]      t,
    input logic [WAYS*TAG_W-1:0] tags,
    input logic [WAYS-1:0]       v
  );
    res_t r;
    int   n;
    r = '0;
    n = 0;
    for (int i = 0; i < WAYS; i++) begin
      if (v[i] && tags[i*TAG_W +: TAG_W] == t) begin
        n++;
        if (n == 1) begin
          r.hit = 1'b1;
          r.oh  = WAYS'(1) << i;
          r.way = IW'(i);
        end
      end
    end
    r.multi = (n > 1);
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Move to mid-cycle, away from the active edge.
  task automatic half();
    #4;
  endtask

  // Scoreboard bookkeeping at the sample point.
  task automatic observe();
    res_t got;
    res_t e;
    got = {out_hit, out_hit_onehot, out_hit_way, obs_multi};
    if (rst) chk("in_ready_in_rst", in_ready, 0);
    if (expect_idle && !rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_hit", out_hit, 0);
      chk("rst_onehot", out_hit_onehot, 0);
      chk("rst_hit_way", out_hit_way, 0);
      chk("rst_multi", obs_multi, 0);
      chk("rst_in_ready", in_ready, 1);
      expect_idle = 0;
    end
    if (rst) begin
      expq.delete();
      held = 0;
      expect_idle = 1;
      return;
    end
    if (out_valid) begin
      if (held) chk("stall_hold", got, held_val);
      if (out_ready) begin
        chk("result_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("hit", out_hit, e.hit);
          chk("onehot", out_hit_onehot, e.oh);
          chk("hit_way", out_hit_way, e.way);
`ifdef TAG_MATCH_MULTI_HIT_EN
          chk("multi_hit", obs_multi, e.multi);
`endif
          delivered++;
        end
        held = 0;
      end else begin
        held     = 1;
        held_val = got;
      end
    end else begin
      held = 0;
    end
    if (in_valid && in_ready) begin
      expq.push_back(model(in_tag, in_way_tags, in_way_valid));
      accepted++;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1();
    half();
    observe();
    adv();
  endtask

  task automatic rand_lookup();
    for (int i = 0; i < WAYS; i++)
      in_way_tags[i*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 3));
    in_tag       = TAG_W'($urandom_range(0, 3));
    in_way_valid = WAYS'($urandom);
  endtask

  int d0;
  int a0;

  initial begin
    checks = 0; errors = 0;
    delivered = 0; accepted = 0;
    held = 0; expect_idle = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_tag = '0;
    in_way_tags = '0;
    in_way_valid = '0;
    #1;
    cyc1();
    cyc1();
    rst = 1'b0;
    cyc1();

    // 1: single hit, two-cycle latency.
    in_way_tags  = {8'h44, 8'h33, 8'h22, 8'h11};
    in_way_valid = 4'b1111;
    in_tag       = 8'h33;
    in_valid     = 1'b1;
    cyc1();
    in_valid = 1'b0;
    half();
    chk("t1_lat1_valid", out_valid, 0);
    observe();
    adv();
    half();
    chk("t1_valid", out_valid, 1);
    chk("t1_hit", out_hit, 1);
    chk("t1_onehot", out_hit_onehot, 4'b0100);
    chk("t1_way", out_hit_way, 2);
    observe();
    adv();

    // 2: matching tag but that way invalid -> miss.
    in_way_valid = 4'b1011;
    in_valid     = 1'b1;
    cyc1();
    in_valid = 1'b0;
    cyc1();
    half();
    chk("t2_valid", out_valid, 1);
    chk("t2_hit", out_hit, 0);
    chk("t2_onehot", out_hit_onehot, 0);
    chk("t2_way", out_hit_way, 0);
    observe();
    adv();

    // 3: multiple matches, lowest wins.
    in_way_tags  = {8'hAA, 8'hAA, 8'h5A, 8'hAA};
    in_way_valid = 4'b1110;
    in_tag       = 8'hAA;
    in_valid     = 1'b1;
    cyc1();
    in_valid = 1'b0;
    cyc1();
    half();
    chk("t3_valid", out_valid, 1);
    chk("t3_onehot", out_hit_onehot, 4'b0100);
    chk("t3_way", out_hit_way, 2);
`ifdef TAG_MATCH_MULTI_HIT_EN
    chk("t3_multi", obs_multi, 1);
`endif
    observe();
    adv();

    // 4: eight back-to-back lookups at full rate.
    d0 = delivered;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rand_lookup();
      half();
      chk("t4_in_ready", in_ready, 1);
      observe();
      adv();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) cyc1();
    chk("t4_delivered", delivered - d0, 8);

    // 5: consumer stalls with three lookups offered.
    d0 = delivered;
    a0 = accepted;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_lookup();
    for (int k = 0; k < 5; k++) begin
      half();
      if (k >= 2) chk("t5_in_ready_low", in_ready, 0);
      observe();
      if (in_ready) rand_lookup();
      adv();
    end
    chk("t5_accepted", accepted - a0, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 6 && accepted - a0 < 3; k++) cyc1();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) cyc1();
    chk("t5_delivered", delivered - d0, 3);

    // 6: reset with two lookups in flight.
    in_valid = 1'b1;
    rand_lookup();
    cyc1();
    rand_lookup();
    cyc1();
    rst = 1'b1;
    cyc1();
    rst = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) cyc1();

    // 7: random valid/ready traffic.
    for (int k = 0; k < 200; k++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_lookup();
      cyc1();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cyc1();
    chk("final_queue_empty", expq.size(), 0);
    chk("final_balance", delivered, accepted - 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
